// File: rtl/alu_system_mem_sequencer_if.sv
// Command handshake and datapath control bundle between a caller and the memory sequencer.
// The master drives Start/Cmd/ByteCount; the slave (sequencer) drives status and controls.
interface alu_system_mem_sequencer_if;
   logic       Start;
   logic [1:0] Cmd;
   logic [2:0] ByteCount;
   logic       Busy;
   logic       Done;
   logic       Error;
   logic       Mem_CS;
   logic       Mem_WR;
   logic       IR_Write;
   logic       IR_LH;
   logic       DR_E;
   logic [1:0] DR_FunSel;
   logic [2:0] ARF_RegSel;
   logic [1:0] ARF_FunSel;
   logic [1:0] ARF_OutDSel;
   logic [1:0] MuxCSel;

   modport master (
      output Start, Cmd, ByteCount,
      input  Busy, Done, Error, Mem_CS, Mem_WR, IR_Write, IR_LH, DR_E, DR_FunSel,
             ARF_RegSel, ARF_FunSel, ARF_OutDSel, MuxCSel
   );

   modport slave (
      input  Start, Cmd, ByteCount,
      output Busy, Done, Error, Mem_CS, Mem_WR, IR_Write, IR_LH, DR_E, DR_FunSel,
             ARF_RegSel, ARF_FunSel, ARF_OutDSel, MuxCSel
   );
endinterface

// File: rtl/alu_system_mem_sequencer.sv
// Multi-cycle FETCH/LOAD/STORE memory sequencer; Moore outputs decoded from state and byte index.
// FETCH completes in 3 cycles, LOAD/STORE in N+1, rejected commands in 1; Start is ignored while busy.
module alu_system_mem_sequencer #(
   parameter logic [1:0] ARF_INC     = 2'b01,
   parameter logic [1:0] DR_CLR_LOAD = 2'b01,
   parameter logic [1:0] DR_SHL_LOAD = 2'b10,
   parameter logic [2:0] PC_REGSEL   = 3'b100,
   parameter logic [1:0] PC_OUTD     = 2'b00,
   parameter logic [2:0] AR_REGSEL   = 3'b001,
   parameter logic [1:0] AR_OUTD     = 2'b10
) (
   input  logic                         i_clk,
   input  logic                         i_rst_n,
   alu_system_mem_sequencer_if.slave    io_seq
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH_L = 3'd1,
      S_FETCH_H = 3'd2,
      S_XFER    = 3'd3,
      S_DONE    = 3'd4
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic       r_store;
   logic [2:0] r_n;
   logic [1:0] r_k;
   logic       r_err;

   logic       w_len_ok;
   logic       w_xfer_cmd;
   logic       w_last;
   logic [2:0] w_byte_sel;

   assign w_len_ok   = (io_seq.ByteCount >= 3'd1) && (io_seq.ByteCount <= 3'd4);
   assign w_xfer_cmd = (io_seq.Cmd == 2'b01) || (io_seq.Cmd == 2'b10);
   assign w_last     = ({1'b0, r_k} == (r_n - 3'd1));
   // Highest ALUOut byte goes to the lowest address, so the selector counts down.
   assign w_byte_sel = r_n - 3'd1 - {1'b0, r_k};

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_store <= 1'b0;
         r_n     <= 3'd0;
         r_k     <= 2'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next;
         case (r_state)
            S_IDLE: begin
               if (io_seq.Start) begin
                  if (io_seq.Cmd == 2'b00) begin
                     r_err <= 1'b0;
                  end else if (w_xfer_cmd && w_len_ok) begin
                     r_store <= io_seq.Cmd[1];
                     r_n     <= io_seq.ByteCount;
                     r_k     <= 2'd0;
                     r_err   <= 1'b0;
                  end else begin
                     r_err <= 1'b1;
                  end
               end
            end
            S_XFER:  r_k   <= r_k + 2'd1;
            S_DONE:  r_err <= 1'b0;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (io_seq.Start) begin
               if (io_seq.Cmd == 2'b00)
                  w_next = S_FETCH_L;
               else if (w_xfer_cmd && w_len_ok)
                  w_next = S_XFER;
               else
                  w_next = S_DONE;
            end
         end
         S_FETCH_L: w_next = S_FETCH_H;
         S_FETCH_H: w_next = S_DONE;
         S_XFER:    if (w_last) w_next = S_DONE;
         S_DONE:    w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   always_comb begin
      io_seq.Busy        = (r_state != S_IDLE);
      io_seq.Done        = 1'b0;
      io_seq.Error       = 1'b0;
      io_seq.Mem_CS      = 1'b1;
      io_seq.Mem_WR      = 1'b0;
      io_seq.IR_Write    = 1'b0;
      io_seq.IR_LH       = 1'b0;
      io_seq.DR_E        = 1'b0;
      io_seq.DR_FunSel   = 2'b00;
      io_seq.ARF_RegSel  = 3'b000;
      io_seq.ARF_FunSel  = 2'b00;
      io_seq.ARF_OutDSel = PC_OUTD;
      io_seq.MuxCSel     = 2'b00;
      case (r_state)
         S_FETCH_L, S_FETCH_H: begin
            io_seq.Mem_CS     = 1'b0;
            io_seq.IR_Write   = 1'b1;
            io_seq.IR_LH      = (r_state == S_FETCH_H);
            io_seq.ARF_RegSel = PC_REGSEL;
            io_seq.ARF_FunSel = ARF_INC;
         end
         S_XFER: begin
            io_seq.Mem_CS      = 1'b0;
            io_seq.ARF_OutDSel = AR_OUTD;
            io_seq.ARF_RegSel  = AR_REGSEL;
            io_seq.ARF_FunSel  = ARF_INC;
            if (r_store) begin
               io_seq.Mem_WR  = 1'b1;
               io_seq.MuxCSel = w_byte_sel[1:0];
            end else begin
               io_seq.DR_E      = 1'b1;
               io_seq.DR_FunSel = (r_k == 2'd0) ? DR_CLR_LOAD : DR_SHL_LOAD;
            end
         end
         S_DONE: begin
            io_seq.Done  = 1'b1;
            io_seq.Error = r_err;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_alu_system_mem_sequencer.sv
// Directed bench: a small memory/IR/DR/ARF harness reacts to the sequencer controls.
module tb_alu_system_mem_sequencer;

   logic clk;
   logic rst_n;
   int   checks;
   int   failures;

   alu_system_mem_sequencer_if bus ();

   alu_system_mem_sequencer dut (
      .i_clk  (clk),
      .i_rst_n(rst_n),
      .io_seq (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath harness
   logic [7:0]  mem [0:255];
   logic [15:0] pc, ar, ir;
   logic [31:0] dr, alu_out;
   logic        ld_mem, ld_regs;
   logic [7:0]  ld_addr, ld_dat;
   logic [15:0] ld_pc, ld_ar;
   logic [31:0] ld_dr;
   logic [15:0] addr;
   logic [7:0]  rd, wd;

   assign addr = (bus.ARF_OutDSel == 2'b10) ? ar : pc;
   assign rd   = mem[addr[7:0]];
   always_comb begin
      wd = 8'h00;
      case (bus.MuxCSel)
         2'd0: wd = alu_out[7:0];
         2'd1: wd = alu_out[15:8];
         2'd2: wd = alu_out[23:16];
         2'd3: wd = alu_out[31:24];
         default: wd = 8'h00;
      endcase
   end

   always @(posedge clk) begin
      if (ld_mem) mem[ld_addr] <= ld_dat;
      if (ld_regs) begin
         pc <= ld_pc;
         ar <= ld_ar;
         dr <= ld_dr;
      end else begin
         if (!bus.Mem_CS && bus.Mem_WR) mem[addr[7:0]] <= wd;
         if (bus.IR_Write) begin
            if (bus.IR_LH) ir[15:8] <= rd;
            else           ir[7:0]  <= rd;
         end
         if (bus.DR_E) begin
            if (bus.DR_FunSel == 2'b01)      dr <= {24'h0, rd};
            else if (bus.DR_FunSel == 2'b10) dr <= {dr[23:0], rd};
         end
         if (bus.ARF_FunSel == 2'b01) begin
            if (bus.ARF_RegSel[2]) pc <= pc + 16'd1;
            if (bus.ARF_RegSel[0]) ar <= ar + 16'd1;
         end
      end
   end

   function automatic logic [18:0] outs();
      return {bus.Busy, bus.Done, bus.Error, bus.Mem_CS, bus.Mem_WR, bus.IR_Write, bus.IR_LH,
              bus.DR_E, bus.DR_FunSel, bus.ARF_RegSel, bus.ARF_FunSel, bus.ARF_OutDSel, bus.MuxCSel};
   endfunction

   function automatic logic [18:0] mk(input logic b, d, e, cs, wr, irw, lh, dre,
                                      input logic [1:0] drf, input logic [2:0] rs,
                                      input logic [1:0] af, od, mux);
      return {b, d, e, cs, wr, irw, lh, dre, drf, rs, af, od, mux};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic poke(input logic [7:0] a, input logic [7:0] d);
      ld_mem = 1'b1; ld_addr = a; ld_dat = d;
      step();
      ld_mem = 1'b0;
   endtask

   task automatic setregs(input logic [15:0] p, input logic [15:0] a, input logic [31:0] d);
      ld_regs = 1'b1; ld_pc = p; ld_ar = a; ld_dr = d;
      step();
      ld_regs = 1'b0;
   endtask

   task automatic start(input logic [1:0] c, input logic [2:0] n);
      bus.Start = 1'b1; bus.Cmd = c; bus.ByteCount = n;
      step();
      bus.Start = 1'b0;
   endtask

   logic [18:0] IDLE_V, DONE_V, ERR_V, FL_V, FH_V, LD0_V, LDN_V;

   initial begin
      checks = 0; failures = 0;
      rst_n = 1'b0; bus.Start = 1'b0; bus.Cmd = 2'b00; bus.ByteCount = 3'd0;
      ld_mem = 1'b0; ld_regs = 1'b0; ld_addr = 8'h0; ld_dat = 8'h0;
      ld_pc = 16'h0; ld_ar = 16'h0; ld_dr = 32'h0; alu_out = 32'h0;

      IDLE_V = mk(0,0,0,1,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00);
      DONE_V = mk(1,1,0,1,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00);
      ERR_V  = mk(1,1,1,1,0,0,0,0,2'b00,3'b000,2'b00,2'b00,2'b00);
      FL_V   = mk(1,0,0,0,0,1,0,0,2'b00,3'b100,2'b01,2'b00,2'b00);
      FH_V   = mk(1,0,0,0,0,1,1,0,2'b00,3'b100,2'b01,2'b00,2'b00);
      LD0_V  = mk(1,0,0,0,0,0,0,1,2'b01,3'b001,2'b01,2'b10,2'b00);
      LDN_V  = mk(1,0,0,0,0,0,0,1,2'b10,3'b001,2'b01,2'b10,2'b00);

      step(); step();
      rst_n = 1'b1;
      chk("reset_outputs", outs(), IDLE_V);

      poke(8'h10, 8'h34); poke(8'h11, 8'h12);
      poke(8'h20, 8'hAA); poke(8'h21, 8'hBB); poke(8'h22, 8'hCC); poke(8'h23, 8'hDD);
      poke(8'h30, 8'h11); poke(8'h31, 8'h22);
      poke(8'h40, 8'h00); poke(8'h41, 8'h00); poke(8'h42, 8'h00);
      poke(8'h50, 8'h00); poke(8'h51, 8'h00); poke(8'h52, 8'h00); poke(8'h53, 8'h00);
      setregs(16'h0010, 16'h0020, 32'h0);
      chk("idle_after_preload", outs(), IDLE_V);

      // FETCH, with a Start pulse during FETCH_L that must be ignored
      start(2'b00, 3'd0);
      chk("fetch_l", outs(), FL_V);
      bus.Start = 1'b1; bus.Cmd = 2'b01; bus.ByteCount = 3'd1;
      step();
      bus.Start = 1'b0;
      chk("fetch_h", outs(), FH_V);
      step();
      chk("fetch_done", outs(), DONE_V);
      chk("fetch_ir", ir, 32'h1234);
      chk("fetch_pc", pc, 32'h0012);
      step();
      chk("fetch_idle", outs(), IDLE_V);

      // LOAD N=4
      start(2'b01, 3'd4);
      chk("load4_k0", outs(), LD0_V);
      step(); chk("load4_k1", outs(), LDN_V);
      step(); chk("load4_k2", outs(), LDN_V);
      step(); chk("load4_k3", outs(), LDN_V);
      step(); chk("load4_done", outs(), DONE_V);
      chk("load4_dr", dr, 32'hAABBCCDD);
      chk("load4_ar", ar, 32'h0024);
      step(); chk("load4_idle", outs(), IDLE_V);

      // LOAD N=2 clears stale DR contents
      setregs(16'h0012, 16'h0030, 32'hFFFFFFFF);
      start(2'b01, 3'd2);
      chk("load2_k0", outs(), LD0_V);
      step(); chk("load2_k1", outs(), LDN_V);
      step(); chk("load2_done", outs(), DONE_V);
      chk("load2_dr", dr, 32'h00001122);
      chk("load2_ar", ar, 32'h0032);
      step();

      // STORE N=3
      alu_out = 32'h00A1B2C3;
      setregs(16'h0012, 16'h0040, 32'h0);
      start(2'b10, 3'd3);
      chk("store3_b0", outs(), mk(1,0,0,0,1,0,0,0,2'b00,3'b001,2'b01,2'b10,2'd2));
      step(); chk("store3_b1", outs(), mk(1,0,0,0,1,0,0,0,2'b00,3'b001,2'b01,2'b10,2'd1));
      step(); chk("store3_b2", outs(), mk(1,0,0,0,1,0,0,0,2'b00,3'b001,2'b01,2'b10,2'd0));
      step(); chk("store3_done", outs(), DONE_V);
      chk("store3_mem40", mem[8'h40], 32'hA1);
      chk("store3_mem41", mem[8'h41], 32'hB2);
      chk("store3_mem42", mem[8'h42], 32'hC3);
      chk("store3_ar", ar, 32'h0043);
      step();

      // Rejected commands
      start(2'b01, 3'd0);
      chk("rej_len0", outs(), ERR_V);
      step(); chk("rej_len0_idle", outs(), IDLE_V);
      start(2'b11, 3'd2);
      chk("rej_cmd11", outs(), ERR_V);
      step(); chk("rej_cmd11_idle", outs(), IDLE_V);
      start(2'b10, 3'd5);
      chk("rej_len5", outs(), ERR_V);
      step(); chk("rej_len5_idle", outs(), IDLE_V);

      // Reset at the edge that would begin the 2nd byte of STORE N=4
      alu_out = 32'h11223344;
      setregs(16'h0012, 16'h0050, 32'h0);
      start(2'b10, 3'd4);
      chk("rst_store_b0", outs(), mk(1,0,0,0,1,0,0,0,2'b00,3'b001,2'b01,2'b10,2'd3));
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      chk("rst_idle", outs(), IDLE_V);
      step(); chk("rst_no_done1", outs(), IDLE_V);
      step(); chk("rst_no_done2", outs(), IDLE_V);
      chk("rst_mem50", mem[8'h50], 32'h11);
      chk("rst_mem51", mem[8'h51], 32'h00);
      chk("rst_ar", ar, 32'h0051);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
